lq_dur_agg: RTL

LQ_DUR_AGG -- requirements
Module: lq_dur_agg

---
 rtl/lq_dur_agg.sv | 128 ++++++++++++
 1 files changed

// File: rtl/lq_dur_agg.sv
// Load-queue duration aggregator: samples load latencies, sums them per batch and
// hands the batch sums to a consumer through a valid/ready report. Optional: LQ_DUR_AGG_MAX_EN.
module lq_dur_agg #(
  parameter int DUR_W         = 10,
  parameter int SUM_W         = 24,
  parameter int BATCH         = 16,
  parameter int SAMPLE_PERIOD = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [7:0]       counter_out,
  output logic [DUR_W-1:0] timestamp_out,
  input  logic             dur_valid,
  input  logic [DUR_W-1:0] dur_dp,
  input  logic [DUR_W-1:0] dur_exec,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [SUM_W-1:0] rpt_sum_dp,
  output logic [SUM_W-1:0] rpt_sum_exec,
  output logic [DUR_W-1:0] rpt_max_exec,
  output logic [7:0]       rpt_drops
);

  localparam int         CNT_W  = $clog2(BATCH) + 1;
  localparam logic [7:0] RELOAD = 8'(SAMPLE_PERIOD - 1);
  localparam logic       IDLE   = 1'b0;
  localparam logic       PEND   = 1'b1;

  logic [13:0]      cyc_q;
  logic [7:0]       smp_q;
  logic [SUM_W-1:0] sum_dp_q, sum_exec_q;
  logic [SUM_W-1:0] sum_dp_nxt, sum_exec_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic             state_q;
  logic [7:0]       drop_q;
  logic             sample, batch_done, hs, load_rpt;

  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                               input logic [DUR_W-1:0] b);
    logic [SUM_W:0] s;
    // NOTE: blocking assignment is correct here: s is a local temporary inside a function.
    s = {1'b0, a} + (SUM_W+1)'(b);
    return s[SUM_W] ? '1 : s[SUM_W-1:0];
  endfunction

  assign sample       = en && dur_valid;
  assign batch_done   = sample && (cnt_q == CNT_W'(BATCH - 1));
  assign hs           = (state_q == PEND) && rpt_ready;
  // A finished batch is published if the slot is free or is being emptied this cycle.
  assign load_rpt     = batch_done && ((state_q == IDLE) || hs);
  assign sum_dp_nxt   = sat_add(sum_dp_q, dur_dp);
  assign sum_exec_nxt = sat_add(sum_exec_q, dur_exec);

  assign counter_out   = smp_q;
  assign timestamp_out = DUR_W'(cyc_q[13:4]);
  assign rpt_valid     = (state_q == PEND);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q <= '0;
      smp_q <= RELOAD;
    end else if (en) begin
      cyc_q <= cyc_q + 14'd1;
      smp_q <= (smp_q == 8'd0) ? RELOAD : smp_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_dp_q   <= '0;
      sum_exec_q <= '0;
      cnt_q      <= '0;
    end else if (batch_done) begin
      sum_dp_q   <= '0;
      sum_exec_q <= '0;
      cnt_q      <= '0;
    end else if (sample) begin
      sum_dp_q   <= sum_dp_nxt;
      sum_exec_q <= sum_exec_nxt;
      cnt_q      <= cnt_q + CNT_W'(1);
    end
  end

  // NOTE: report registers are reset too, since they drive outputs that must read 0 in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      drop_q       <= '0;
      rpt_sum_dp   <= '0;
      rpt_sum_exec <= '0;
      rpt_drops    <= '0;
    end else if (load_rpt) begin
      state_q      <= PEND;
      drop_q       <= '0;
      rpt_sum_dp   <= sum_dp_nxt;
      rpt_sum_exec <= sum_exec_nxt;
      rpt_drops    <= drop_q;
    end else if (batch_done) begin
      drop_q <= (drop_q == 8'hff) ? drop_q : drop_q + 8'd1;
    end else if (hs) begin
      state_q <= IDLE;
      drop_q  <= '0;
    end
  end

`ifdef LQ_DUR_AGG_MAX_EN
  logic [DUR_W-1:0] max_q, max_nxt, rpt_max_q;

  assign max_nxt      = (dur_exec > max_q) ? dur_exec : max_q;
  assign rpt_max_exec = rpt_max_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_q     <= '0;
      rpt_max_q <= '0;
    end else begin
      if (batch_done)  max_q <= '0;
      else if (sample) max_q <= max_nxt;
      if (load_rpt)    rpt_max_q <= max_nxt;
    end
  end
`else
  assign rpt_max_exec = '0;
`endif

endmodule
